wb_return_queue: RTL

- Parametrised next-generation writeback stage. Buffers up to DEPTH in-flight instructions leaving the M stage and waits for variable-latency, in-order memory load responses.
- Selects the result source, applies byte-lane extraction with sign/zero extension, and retires register writes in program order.
- Sits between the M stage and the register file. Exerts backpressure on M via a ready signal.

---
 rtl/wb_return_queue_pkg.sv | 35 +++
 rtl/wb_return_queue_lane_extender.sv | 52 +++++
 rtl/wb_return_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb_return_queue_pkg.sv
// ============================================================================
// Module   : wb_return_queue_pkg
// Purpose  : Writeback control types (result source, truncation) and helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_return_queue_pkg;

  typedef enum logic [1:0] {
    RES_COMPUTE = 2'd0,
    RES_MEMORY  = 2'd1,
    RES_PCPLUS4 = 2'd2,
    RES_CSR     = 2'd3
  } result_src_e;

  typedef enum logic [2:0] {
    TR_FULL   = 3'd0,
    TR_BYTE_S = 3'd1,
    TR_BYTE_U = 3'd2,
    TR_HALF_S = 3'd3,
    TR_HALF_U = 3'd4,
    TR_WORD_S = 3'd5,
    TR_WORD_U = 3'd6
  } trunc_type_e;

  localparam int unsigned c_BYTE_BITS = 8;

  function automatic logic is_memory_src(input logic [1:0] src);
    return src == RES_MEMORY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_return_queue_lane_extender.sv
// ============================================================================
// Module   : wb_return_queue_lane_extender
// Purpose  : Combinational byte-lane extraction with sign/zero extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_return_queue_lane_extender
  import wb_return_queue_pkg::*;
#(
  parameter  int XLEN     = 64,
  localparam int OFF_BITS = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]     Data_i,
  input  logic [2:0]          TruncType_i,
  input  logic [OFF_BITS-1:0] TruncSrc_i,
  output logic [XLEN-1:0]     Result_o
);

  logic [31:0]     w_lane;
  logic [XLEN-1:0] w_word_s;
  logic [XLEN-1:0] w_word_u;

  assign w_lane = 32'(Data_i >> {TruncSrc_i, 3'b000});

  // On a 32-bit datapath a word already fills the register, so word types pass through.
  generate
    if (XLEN == 64) begin : g_word64
      assign w_word_s = {{32{w_lane[31]}}, w_lane};
      assign w_word_u = {32'b0, w_lane};
    end else begin : g_word32
      assign w_word_s = Data_i;
      assign w_word_u = Data_i;
    end
  endgenerate

  always_comb begin
    Result_o = Data_i;
    case (TruncType_i)
      TR_BYTE_S: Result_o = {{(XLEN-c_BYTE_BITS){w_lane[7]}}, w_lane[7:0]};
      TR_BYTE_U: Result_o = {{(XLEN-c_BYTE_BITS){1'b0}}, w_lane[7:0]};
      TR_HALF_S: Result_o = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      TR_HALF_U: Result_o = {{(XLEN-16){1'b0}}, w_lane[15:0]};
      TR_WORD_S: Result_o = w_word_s;
      TR_WORD_U: Result_o = w_word_u;
      default:   Result_o = Data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_return_queue.sv
// ============================================================================
// Module   : wb_return_queue
// Purpose  : Writeback queue; waits for in-order load responses, retires in order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_return_queue
  import wb_return_queue_pkg::*;
#(
  parameter  int XLEN     = 64,
  parameter  int DEPTH    = 2,
  parameter  int RD_BITS  = 5,
  localparam int OFF_BITS = $clog2(XLEN / 8)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                InValid_W,
  output logic                InReady_W,
  input  logic [1:0]          ResultSrc_W,
  input  logic [2:0]          TruncType_W,
  input  logic [OFF_BITS-1:0] TruncSrc_W,
  input  logic [RD_BITS-1:0]  RdAddr_In,
  input  logic [XLEN-1:0]     ComputeResult_W,
  input  logic [XLEN-1:0]     PcPlus4_W,
  input  logic [XLEN-1:0]     CsrResult_W,
  input  logic                MemRespValid,
  input  logic [XLEN-1:0]     MemRespData,
  input  logic                MemRespErr,
  output logic                RegWrite_W,
  output logic [RD_BITS-1:0]  RdAddr_W,
  output logic [XLEN-1:0]     Rd1_W,
  output logic                LoadFault_W,
  output logic                SpuriousResp_W,
  output logic                Busy_W
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]          src_q   [DEPTH];
  logic [2:0]          trunc_q [DEPTH];
  logic [OFF_BITS-1:0] off_q   [DEPTH];
  logic [RD_BITS-1:0]  rd_q    [DEPTH];
  logic [XLEN-1:0]     data_q  [DEPTH];
  logic [DEPTH-1:0]    done_q, err_q;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                RegWrite_q, LoadFault_q, SpuriousResp_q;
  logic [RD_BITS-1:0]  RdAddr_q;
  logic [XLEN-1:0]     Rd1_q;

  logic                w_empty, w_acc, w_bypass, w_push;
  logic                w_pend_hit, w_resp_fire, w_spurious;
  logic [PW-1:0]       w_pend_idx, w_scan_idx;
  logic                w_head_resp, w_head_ready, w_retire;
  logic [XLEN-1:0]     w_in_data, w_ret_data, w_ext;
  logic [2:0]          w_ret_trunc;
  logic [OFF_BITS-1:0] w_ret_off;
  logic [RD_BITS-1:0]  w_ret_rd;
  logic                w_ret_err;

  assign InReady_W = (count_q != CW'(DEPTH));
  assign Busy_W    = (count_q != '0);
  assign w_empty   = (count_q == '0);
  assign w_acc     = InValid_W && InReady_W;
  // An already-complete result entering an empty queue retires straight away.
  assign w_bypass  = w_acc && w_empty && !is_memory_src(ResultSrc_W);
  assign w_push    = w_acc && !w_bypass;

  always_comb begin
    w_in_data = ComputeResult_W;
    case (ResultSrc_W)
      RES_PCPLUS4: w_in_data = PcPlus4_W;
      RES_CSR:     w_in_data = CsrResult_W;
      default:     w_in_data = ComputeResult_W;
    endcase
  end

  // Oldest outstanding load, searched from head in program order.
  always_comb begin
    w_pend_hit = 1'b0;
    w_pend_idx = head_q;
    w_scan_idx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = head_q + PW'(k);
      if (!w_pend_hit && (CW'(k) < count_q) && !done_q[w_scan_idx] &&
          is_memory_src(src_q[w_scan_idx])) begin
        w_pend_hit = 1'b1;
        w_pend_idx = w_scan_idx;
      end
    end
  end

  assign w_resp_fire  = MemRespValid && w_pend_hit;
  assign w_spurious   = MemRespValid && !w_pend_hit;
  assign w_head_resp  = w_resp_fire && (w_pend_idx == head_q);
  assign w_head_ready = !w_empty && (done_q[head_q] || w_head_resp);
  assign w_retire     = w_head_ready || w_bypass;

  always_comb begin
    w_ret_trunc = trunc_q[head_q];
    w_ret_off   = off_q[head_q];
    w_ret_rd    = rd_q[head_q];
    w_ret_data  = w_head_resp ? MemRespData : data_q[head_q];
    w_ret_err   = w_head_resp ? MemRespErr  : err_q[head_q];
    if (w_bypass) begin
      w_ret_trunc = TruncType_W;
      w_ret_off   = TruncSrc_W;
      w_ret_rd    = RdAddr_In;
      w_ret_data  = w_in_data;
      w_ret_err   = 1'b0;
    end
  end

  wb_return_queue_lane_extender #(.XLEN(XLEN)) u_lane_extender (
    .Data_i      (w_ret_data),
    .TruncType_i (w_ret_trunc),
    .TruncSrc_i  (w_ret_off),
    .Result_o    (w_ext)
  );

  always_comb begin
    head_d  = head_q + PW'(w_head_ready);
    tail_d  = tail_q + PW'(w_push);
    count_d = count_q + CW'(w_push) - CW'(w_head_ready);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      src_q[tail_q]   <= ResultSrc_W;
      trunc_q[tail_q] <= TruncType_W;
      off_q[tail_q]   <= TruncSrc_W;
      rd_q[tail_q]    <= RdAddr_In;
      data_q[tail_q]  <= w_in_data;
    end
    if (w_resp_fire) begin
      data_q[w_pend_idx] <= MemRespData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      done_q         <= '0;
      err_q          <= '0;
      RegWrite_q     <= 1'b0;
      LoadFault_q    <= 1'b0;
      SpuriousResp_q <= 1'b0;
      RdAddr_q       <= '0;
      Rd1_q          <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (w_push) begin
        done_q[tail_q] <= !is_memory_src(ResultSrc_W);
        err_q[tail_q]  <= 1'b0;
      end
      if (w_resp_fire) begin
        done_q[w_pend_idx] <= 1'b1;
        err_q[w_pend_idx]  <= MemRespErr;
      end
      RegWrite_q     <= w_retire && !w_ret_err && (w_ret_rd != '0);
      LoadFault_q    <= w_retire && w_ret_err;
      SpuriousResp_q <= w_spurious;
      RdAddr_q       <= w_retire ? w_ret_rd : '0;
      Rd1_q          <= w_retire ? w_ext : '0;
    end
  end

  assign RegWrite_W     = RegWrite_q;
  assign LoadFault_W    = LoadFault_q;
  assign SpuriousResp_W = SpuriousResp_q;
  assign RdAddr_W       = RdAddr_q;
  assign Rd1_W          = Rd1_q;

endmodule

`default_nettype wire
